// File: rtl/layer_match_sequencer.sv
// layer_match_sequencer
// Shares one single-layer pad matcher across NUM_LAYERS layers per trigger
// event, collects the per-layer match bits and compares the matched-layer
// count against a coincidence threshold. Match maps are double-buffered:
// writes land in shadow maps and are copied to the active maps only between
// events, so an event in flight always sees one consistent map set.
//
// state | meaning
// IDLE  | waiting for an event; applies a pending commit (blocks accept)
// SCAN  | one layer per cycle presented to the shared matcher
// DONE  | one-cycle result strobe, results registered

module layer_match_sequencer #(
  parameter int NUM_LAYERS = 4,
  parameter int PAD_W      = 4,
  parameter int LYR_W      = 2,
  parameter int CNT_W      = 4,
  localparam int MAP_W     = 2 ** PAD_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [LYR_W-1:0]            cfg_layer,
  input  logic [MAP_W-1:0]            cfg_map,
  input  logic                        cfg_commit,
  input  logic [CNT_W-1:0]            threshold,
  input  logic                        evt_valid,
  output logic                        evt_ready,
  input  logic [NUM_LAYERS*PAD_W-1:0] evt_pads,
  output logic [PAD_W-1:0]            mm_pad_data,
  output logic [MAP_W-1:0]            mm_map,
  input  logic                        mm_matched,
  output logic                        trig_valid,
  output logic                        trig_hit,
  output logic [CNT_W-1:0]            trig_count,
  output logic [NUM_LAYERS-1:0]       trig_layer_hits,
  output logic                        commit_pending
);

  localparam logic [LYR_W-1:0] IDX_LAST = LYR_W'(NUM_LAYERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [LYR_W-1:0]              idx_q, idx_d;
  logic [NUM_LAYERS*PAD_W-1:0]   pads_q, pads_d;
  logic [CNT_W-1:0]              thr_q, thr_d;
  logic [NUM_LAYERS-1:0]         hits_q, hits_d;
  logic                          pend_q, pend_d;
  logic [MAP_W-1:0]              shadow_q [NUM_LAYERS];
  logic [MAP_W-1:0]              shadow_d [NUM_LAYERS];
  logic [MAP_W-1:0]              active_q [NUM_LAYERS];
  logic [MAP_W-1:0]              active_d [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]         lhits_q, lhits_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          hit_q, hit_d;
  logic [CNT_W-1:0]              pop_c;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: event latch, scan index, maps, registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      pads_q   <= '0;
      thr_q    <= '0;
      hits_q   <= '0;
      pend_q   <= 1'b0;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      lhits_q  <= '0;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      pads_q   <= pads_d;
      thr_q    <= thr_d;
      hits_q   <= hits_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      lhits_q  <= lhits_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
    end
  end

  // Next-state, scan sequencing, map write/commit and result computation
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pads_d   = pads_q;
    thr_d    = thr_q;
    hits_d   = hits_q;
    pend_d   = pend_q | cfg_commit;
    shadow_d = shadow_q;
    active_d = active_q;
    lhits_d  = lhits_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    pop_c    = '0;

    // Shadow writes are allowed in any state; out-of-range layers fall through.
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (cfg_we && (cfg_layer == LYR_W'(k))) begin
        shadow_d[k] = cfg_map;
      end
    end

    case (state_q)
      ST_IDLE: begin
        // Copy from shadow_d so a same-cycle write is part of the commit; any
        // commit request arriving on this edge is folded into this copy.
        if (pend_q) begin
          active_d = shadow_d;
          pend_d   = 1'b0;
        end else if (evt_valid) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          pads_d  = evt_pads;
          thr_d   = threshold;
          hits_d  = '0;
        end
      end
      ST_SCAN: begin
        for (int k = 0; k < NUM_LAYERS; k++) begin
          if (idx_q == LYR_W'(k)) begin
            hits_d[k] = mm_matched;
          end
        end
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          for (int k = 0; k < NUM_LAYERS; k++) begin
            pop_c = pop_c + CNT_W'(hits_d[k]);
          end
          lhits_d = hits_d;
          cnt_d   = pop_c;
          hit_d   = (pop_c >= thr_q);
        end else begin
          idx_d = idx_q + LYR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Shared matcher drive: registered pad/map of the current layer, zero outside SCAN
  always_comb begin
    mm_pad_data = '0;
    mm_map      = '0;
    if (state_q == ST_SCAN) begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        if (idx_q == LYR_W'(k)) begin
          mm_pad_data = pads_q[k*PAD_W +: PAD_W];
          mm_map      = active_q[k];
        end
      end
    end
  end

  // rst gates ready so nothing is offered while reset is held
  assign evt_ready       = (state_q == ST_IDLE) && !pend_q && !rst;
  assign trig_valid      = (state_q == ST_DONE);
  assign trig_hit        = hit_q;
  assign trig_count      = cnt_q;
  assign trig_layer_hits = lhits_q;
  assign commit_pending  = pend_q;

endmodule
